i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning the WAIT-state watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  in  1  requester N (N=0,1) has a transaction pending.
REQ-005 SHALL have ports reqN_rw  in  1  1=read (16-bit burst), 0=write (one byte).
REQ-006 SHALL have ports reqN_slave, reqN_reg, reqN_wdata  in  8 each  slave address (e.g. 0x32, 0x3C), register address, write data.
REQ-007 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-008 SHALL have ports reqN_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports reqN_rdata  out  16  read result; reqN_err  out  1  NACK or timeout.
REQ-010 SHALL have ports ctl_start  out  1, ctl_rw  out  1, ctl_slave/ctl_reg/ctl_wdata  out  8  command to the I2C controller.
REQ-011 SHALL have ports ctl_busy  in  1, ctl_done  in  1, ctl_nack  in  1, ctl_rdata  in  16  controller status and result.
REQ-012 SHALL have port ctl_abort  out  1  one-cycle abort pulse to the controller.
REQ-013 SHALL have ports owner  out  1  index of current/last granted requester; busy  out  1  high in any state but IDLE; xact_count  out  16  completed transactions.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-015 IDLE: reqN_ready combinational, high only for granted requester; transfer on valid&&ready; fields latched, owner updated, go ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: both valid -> grant the requester not in owner; one valid -> grant it.
REQ-017 ISSUE: if ctl_busy=0, pulse ctl_start one cycle with latched fields and go WAIT; else hold in ISSUE.
REQ-018 ctl_* command outputs SHALL hold latched values from ISSUE until RESP exit.
REQ-019 WAIT: on ctl_done, capture rdata = ctl_rdata for reads, 0x0000 for writes; err = ctl_nack; go RESP.
REQ-020 RESP: pulse reqN_done of owner one cycle with rdata/err valid same cycle; xact_count +1 (wraps 0xFFFF->0x0000); return IDLE.
REQ-021 Minimum latency: accept at cycle T, ctl_start at T+1, done at ctl_done cycle +1.
REQ-022 ctl_done/ctl_nack outside WAIT SHALL be ignored.
REQ-023 reqN_rdata/reqN_err SHALL hold until next RESP of that requester; the non-owner's outputs are untouched.
REQ-024 Dropping reqN_valid after acceptance SHALL NOT affect the in-flight transaction.

Reset
REQ-025 On rst: state IDLE, owner=1 (req0 wins first contention), all ready/done/start/abort 0, ctl fields 0, rdata 0x0000, err 0, xact_count 0, watchdog 0.
REQ-026 rst mid-transaction SHALL return to IDLE immediately with no done pulse and no ctl_abort.

Configuration
REQ-027 Macro I2C_ARB_TIMEOUT_EN defined: watchdog counts cycles in WAIT, cleared on entry; on reaching TIMEOUT_CYCLES without ctl_done, pulse ctl_abort one cycle, set err=1, rdata=0x0000, go RESP.
REQ-028 Macro undefined: no watchdog logic, ctl_abort tied 0, WAIT persists until ctl_done.

Verification
REQ-029 req0 write slave 0x32 reg 0x20 data 0x37, ctl_done after 50 cycles, nack=0 -> ctl_start at T+1 with those fields, req0_done one cycle after ctl_done, err=0, xact_count=1.
REQ-030 req1 read slave 0x3C reg 0x03, ctl_rdata=0x12AB -> req1_rdata=0x12AB, req0 outputs unchanged.
REQ-031 Both valid from reset, held for 3 transactions -> grant order req0, req1, req0.
REQ-032 ctl_busy high 10 cycles after accept -> ctl_start delayed exactly until first cycle ctl_busy=0.
REQ-033 With I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no ctl_done -> ctl_abort at WAIT cycle 100, done with err=1, rdata=0x0000; without macro -> busy stays 1.
REQ-034 rst asserted in WAIT, ctl_done pulsed after release -> no reqN_done, xact_count=0.

Source files
------------

// File: rtl/i2c_bus_arbiter_if.sv
// Bundle of requester, controller and status signals around i2c_bus_arbiter.
// master: the arbiter side. slave: the requesters/controller/environment side.
interface i2c_bus_arbiter_if;
  logic        req0_valid;
  logic        req0_rw;
  logic [7:0]  req0_slave;
  logic [7:0]  req0_reg;
  logic [7:0]  req0_wdata;
  logic        req0_ready;
  logic        req0_done;
  logic [15:0] req0_rdata;
  logic        req0_err;

  logic        req1_valid;
  logic        req1_rw;
  logic [7:0]  req1_slave;
  logic [7:0]  req1_reg;
  logic [7:0]  req1_wdata;
  logic        req1_ready;
  logic        req1_done;
  logic [15:0] req1_rdata;
  logic        req1_err;

  logic        ctl_start;
  logic        ctl_rw;
  logic [7:0]  ctl_slave;
  logic [7:0]  ctl_reg;
  logic [7:0]  ctl_wdata;
  logic        ctl_busy;
  logic        ctl_done;
  logic        ctl_nack;
  logic [15:0] ctl_rdata;
  logic        ctl_abort;

  logic        owner;
  logic        busy;
  logic [15:0] xact_count;

  modport master (
    input  req0_valid, req0_rw, req0_slave, req0_reg, req0_wdata,
    input  req1_valid, req1_rw, req1_slave, req1_reg, req1_wdata,
    input  ctl_busy, ctl_done, ctl_nack, ctl_rdata,
    output req0_ready, req0_done, req0_rdata, req0_err,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output ctl_start, ctl_rw, ctl_slave, ctl_reg, ctl_wdata, ctl_abort,
    output owner, busy, xact_count
  );

  modport slave (
    output req0_valid, req0_rw, req0_slave, req0_reg, req0_wdata,
    output req1_valid, req1_rw, req1_slave, req1_reg, req1_wdata,
    output ctl_busy, ctl_done, ctl_nack, ctl_rdata,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  ctl_start, ctl_rw, ctl_slave, ctl_reg, ctl_wdata, ctl_abort,
    input  owner, busy, xact_count
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin arbiter letting two requesters share one I2C controller.
// Defining I2C_ARB_TIMEOUT_EN adds a WAIT-state watchdog that aborts after TIMEOUT_CYCLES.
module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input logic               clk,
  input logic               rst,
  i2c_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_owner, w_owner_d;
  logic        r_rw, w_rw_d;
  logic [7:0]  r_slave, w_slave_d;
  logic [7:0]  r_reg, w_reg_d;
  logic [7:0]  r_wdata, w_wdata_d;
  logic [15:0] r_rdata0, w_rdata0_d;
  logic [15:0] r_rdata1, w_rdata1_d;
  logic        r_err0, w_err0_d;
  logic        r_err1, w_err1_d;
  logic [15:0] r_xact, w_xact_d;

  logic        w_any, w_grant;
  logic        w_ready0, w_ready1, w_start, w_done0, w_done1;
  logic        w_cmpl, w_cmpl_err;
  logic [15:0] w_cmpl_rdata;
  logic        w_expire;

  assign w_any   = bus.req0_valid | bus.req1_valid;
  // Contention goes to whoever was not granted last; otherwise to the lone requester.
  assign w_grant = (bus.req0_valid && bus.req1_valid) ? ~r_owner : bus.req1_valid;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] r_wdog, w_wdog_d;

  // Watchdog counts WAIT cycles; held at zero elsewhere so every WAIT entry starts fresh.
  always_comb begin
    w_wdog_d = '0;
    if (r_state == StWait) w_wdog_d = r_wdog + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wdog <= '0;
    else     r_wdog <= w_wdog_d;
  end

  // ctl_done wins if it lands on the expiry cycle.
  assign w_expire = (r_state == StWait) && !bus.ctl_done &&
                    (r_wdog == WdogW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_expire     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Next-state, handshake outputs and datapath next values.
  always_comb begin
    w_state_d    = r_state;
    w_owner_d    = r_owner;
    w_rw_d       = r_rw;
    w_slave_d    = r_slave;
    w_reg_d      = r_reg;
    w_wdata_d    = r_wdata;
    w_rdata0_d   = r_rdata0;
    w_rdata1_d   = r_rdata1;
    w_err0_d     = r_err0;
    w_err1_d     = r_err1;
    w_xact_d     = r_xact;
    w_ready0     = 1'b0;
    w_ready1     = 1'b0;
    w_start      = 1'b0;
    w_done0      = 1'b0;
    w_done1      = 1'b0;
    w_cmpl       = 1'b0;
    w_cmpl_err   = 1'b0;
    w_cmpl_rdata = 16'h0000;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_ready0  = ~w_grant;
          w_ready1  = w_grant;
          w_owner_d = w_grant;
          w_rw_d    = w_grant ? bus.req1_rw    : bus.req0_rw;
          w_slave_d = w_grant ? bus.req1_slave : bus.req0_slave;
          w_reg_d   = w_grant ? bus.req1_reg   : bus.req0_reg;
          w_wdata_d = w_grant ? bus.req1_wdata : bus.req0_wdata;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (!bus.ctl_busy) begin
          w_start   = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (bus.ctl_done) begin
          w_cmpl       = 1'b1;
          w_cmpl_rdata = r_rw ? bus.ctl_rdata : 16'h0000;
          w_cmpl_err   = bus.ctl_nack;
          w_state_d    = StResp;
        end else if (w_expire) begin
          w_cmpl     = 1'b1;
          w_cmpl_err = 1'b1;
          w_state_d  = StResp;
        end
      end
      StResp: begin
        w_done0   = ~r_owner;
        w_done1   = r_owner;
        w_xact_d  = r_xact + 16'd1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Results land in the owner's registers so they are valid during the RESP pulse.
    if (w_cmpl) begin
      if (r_owner) begin
        w_rdata1_d = w_cmpl_rdata;
        w_err1_d   = w_cmpl_err;
      end else begin
        w_rdata0_d = w_cmpl_rdata;
        w_err0_d   = w_cmpl_err;
      end
    end
  end

  // Datapath registers; owner resets to 1 so req0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= 1'b1;
      r_rw     <= 1'b0;
      r_slave  <= 8'h00;
      r_reg    <= 8'h00;
      r_wdata  <= 8'h00;
      r_rdata0 <= 16'h0000;
      r_rdata1 <= 16'h0000;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_xact   <= 16'h0000;
    end else begin
      r_owner  <= w_owner_d;
      r_rw     <= w_rw_d;
      r_slave  <= w_slave_d;
      r_reg    <= w_reg_d;
      r_wdata  <= w_wdata_d;
      r_rdata0 <= w_rdata0_d;
      r_rdata1 <= w_rdata1_d;
      r_err0   <= w_err0_d;
      r_err1   <= w_err1_d;
      r_xact   <= w_xact_d;
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.req0_done  = w_done0;
  assign bus.req1_done  = w_done1;
  assign bus.req0_rdata = r_rdata0;
  assign bus.req1_rdata = r_rdata1;
  assign bus.req0_err   = r_err0;
  assign bus.req1_err   = r_err1;
  assign bus.ctl_start  = w_start;
  assign bus.ctl_rw     = r_rw;
  assign bus.ctl_slave  = r_slave;
  assign bus.ctl_reg    = r_reg;
  assign bus.ctl_wdata  = r_wdata;
  assign bus.ctl_abort  = w_expire;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state != StIdle);
  assign bus.xact_count = r_xact;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: drivers push expected ctl_start/done/abort
// events into queues, a negedge monitor pops and compares whenever the DUT shows one.
module tb_i2c_bus_arbiter;
  localparam int unsigned Tmo = 100;

  logic clk;
  logic rst;
  i2c_bus_arbiter_if bus ();

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [7:0] slv;
    logic [7:0] rg;
    logic [7:0] wd;
  } start_t;

  typedef struct {
    int          cyc;
    int          who;
    logic [15:0] rd;
    logic        err;
    logic [15:0] ord;
    logic        oerr;
  } done_t;

  start_t q_start[$];
  done_t  q_done[$];
  int     q_abort[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [15:0] mdl_rd[2];
  logic        mdl_err[2];
  logic [15:0] mdl_xact;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every DUT event against the head of its queue.
  start_t ms;
  done_t  md;
  int     ma;
  always @(negedge clk) begin
    if (bus.ctl_start) begin
      if (q_start.size() == 0) chk("spurious_start", 32'(bus.ctl_start), 32'd0);
      else begin
        ms = q_start.pop_front();
        chk("start_cycle", cyc, ms.cyc);
        chk("start_rw", 32'(bus.ctl_rw), 32'(ms.rw));
        chk("start_slave", 32'(bus.ctl_slave), 32'(ms.slv));
        chk("start_reg", 32'(bus.ctl_reg), 32'(ms.rg));
        chk("start_wdata", 32'(bus.ctl_wdata), 32'(ms.wd));
      end
    end
    if (bus.req0_done || bus.req1_done) begin
      if (q_done.size() == 0) chk("spurious_done", 32'({bus.req1_done, bus.req0_done}), 32'd0);
      else begin
        md = q_done.pop_front();
        chk("done_cycle", cyc, md.cyc);
        chk("done_who", 32'({bus.req1_done, bus.req0_done}), (md.who == 1) ? 32'd2 : 32'd1);
        if (md.who == 0) begin
          chk("done_rdata", 32'(bus.req0_rdata), 32'(md.rd));
          chk("done_err", 32'(bus.req0_err), 32'(md.err));
          chk("other_rdata", 32'(bus.req1_rdata), 32'(md.ord));
          chk("other_err", 32'(bus.req1_err), 32'(md.oerr));
        end else begin
          chk("done_rdata", 32'(bus.req1_rdata), 32'(md.rd));
          chk("done_err", 32'(bus.req1_err), 32'(md.err));
          chk("other_rdata", 32'(bus.req0_rdata), 32'(md.ord));
          chk("other_err", 32'(bus.req0_err), 32'(md.oerr));
        end
      end
    end
    if (bus.ctl_abort) begin
      if (q_abort.size() == 0) chk("spurious_abort", 32'(bus.ctl_abort), 32'd0);
      else begin
        ma = q_abort.pop_front();
        chk("abort_cycle", cyc, ma);
      end
    end
  end

  task automatic model_reset();
    mdl_rd[0] = 16'h0000; mdl_rd[1] = 16'h0000;
    mdl_err[0] = 1'b0;    mdl_err[1] = 1'b0;
    mdl_xact = 16'h0000;
  endtask

  task automatic reset_checks();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd1);
    chk("rst_xact", 32'(bus.xact_count), 32'd0);
    chk("rst_rdata0", 32'(bus.req0_rdata), 32'd0);
    chk("rst_rdata1", 32'(bus.req1_rdata), 32'd0);
    chk("rst_err0", 32'(bus.req0_err), 32'd0);
    chk("rst_err1", 32'(bus.req1_err), 32'd0);
    chk("rst_start", 32'(bus.ctl_start), 32'd0);
    chk("rst_abort", 32'(bus.ctl_abort), 32'd0);
    chk("rst_slave", 32'(bus.ctl_slave), 32'd0);
  endtask

  task automatic set_req(input int who, input logic rw, input logic [7:0] s,
                         input logic [7:0] r, input logic [7:0] w);
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_rw = rw;
      bus.req0_slave = s; bus.req0_reg = r; bus.req0_wdata = w;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_rw = rw;
      bus.req1_slave = s; bus.req1_reg = r; bus.req1_wdata = w;
    end
  endtask

  // Waits (bounded) for a ready; returns the accept cycle.
  task automatic await_grant(input int exp_who, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        chk("grant_onehot", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
        chk("grant_who", bus.req1_ready ? 32'd1 : 32'd0, 32'(exp_who));
        t  = cyc;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      n_bad++;
      $display("FAIL grant_timeout: no ready within 50 cycles, want req%0d", exp_who);
    end
  endtask

  task automatic push_start(input int c, input logic rw, input logic [7:0] s,
                            input logic [7:0] r, input logic [7:0] w);
    start_t e;
    e.cyc = c; e.rw = rw; e.slv = s; e.rg = r; e.wd = w;
    q_start.push_back(e);
  endtask

  // Called #1 into the ctl_start cycle; completes the transaction after dly cycles.
  task automatic respond(input int who, input logic rw, input logic [7:0] slv, input int dly,
                         input logic [15:0] rd, input logic nack);
    done_t e;
    repeat (dly) @(posedge clk);
    #1;
    chk("ctl_slave_hold", 32'(bus.ctl_slave), 32'(slv));
    chk("busy_in_wait", 32'(bus.busy), 32'd1);
    bus.ctl_done = 1'b1; bus.ctl_nack = nack; bus.ctl_rdata = rd;
    e.cyc = cyc + 1; e.who = who; e.rd = rw ? rd : 16'h0000; e.err = nack;
    e.ord = mdl_rd[1-who]; e.oerr = mdl_err[1-who];
    q_done.push_back(e);
    mdl_rd[who] = e.rd; mdl_err[who] = nack; mdl_xact = mdl_xact + 16'd1;
    @(posedge clk); #1;
    bus.ctl_done = 1'b0; bus.ctl_nack = 1'b0; bus.ctl_rdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("xact_count", 32'(bus.xact_count), 32'(mdl_xact));
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  task automatic drop_valid(input int who);
    if (who == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  // One complete transaction with optional controller-busy stall after accept.
  task automatic run_xact(input int who, input logic rw, input logic [7:0] s,
                          input logic [7:0] r, input logic [7:0] w, input int busy_cyc,
                          input int dly, input logic [15:0] rd, input logic nack);
    int t;
    bit ok;
    set_req(who, rw, s, r, w);
    if (busy_cyc > 0) bus.ctl_busy = 1'b1;
    await_grant(who, t, ok);
    if (!ok) begin
      drop_valid(who);
      bus.ctl_busy = 1'b0;
      return;
    end
    push_start(t + 1 + busy_cyc, rw, s, r, w);
    @(posedge clk); #1;
    drop_valid(who);
    if (busy_cyc >= 2) begin
      // Stray ctl_done/nack while still in ISSUE must be ignored.
      bus.ctl_done = 1'b1; bus.ctl_nack = 1'b1;
      @(posedge clk); #1;
      bus.ctl_done = 1'b0; bus.ctl_nack = 1'b0;
      repeat (busy_cyc - 1) @(posedge clk);
      #1;
      bus.ctl_busy = 1'b0;
    end else if (busy_cyc == 1) begin
      @(posedge clk); #1;
      bus.ctl_busy = 1'b0;
    end
    respond(who, rw, s, dly, rd, nack);
  endtask

  initial begin
    int t;
    bit ok;
    logic [15:0] cont_rd[3];
    int cont_who[3];
    rst = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_rw = 1'b0;
    bus.req0_slave = 8'h00; bus.req0_reg = 8'h00; bus.req0_wdata = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_rw = 1'b0;
    bus.req1_slave = 8'h00; bus.req1_reg = 8'h00; bus.req1_wdata = 8'h00;
    bus.ctl_busy = 1'b0; bus.ctl_done = 1'b0; bus.ctl_nack = 1'b0; bus.ctl_rdata = 16'h0000;
    model_reset();
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;
    @(posedge clk); #1;

    // req0 write, done 50 cycles after start.
    run_xact(0, 1'b0, 8'h32, 8'h20, 8'h37, 0, 50, 16'hFFFF, 1'b0);
    // req0 read with NACK so req0 holds a distinctive result.
    run_xact(0, 1'b1, 8'h32, 8'h28, 8'h00, 0, 3, 16'h5A5A, 1'b1);
    // req1 read; req0 result must stay untouched.
    run_xact(1, 1'b1, 8'h3C, 8'h03, 8'h00, 0, 7, 16'h12AB, 1'b0);
    // Controller busy for 10 cycles after accept.
    run_xact(1, 1'b0, 8'h3C, 8'h10, 8'hA5, 10, 4, 16'h0000, 1'b0);

    // No ctl_done at all.
    set_req(0, 1'b1, 8'h32, 8'h0F, 8'h00);
    await_grant(0, t, ok);
    if (ok) begin
      push_start(t + 1, 1'b1, 8'h32, 8'h0F, 8'h00);
      @(posedge clk); #1;
      drop_valid(0);
      bus.ctl_rdata = 16'hBEEF;
`ifdef I2C_ARB_TIMEOUT_EN
      begin
        done_t e;
        q_abort.push_back(cyc + Tmo);
        e.cyc = cyc + Tmo + 1; e.who = 0; e.rd = 16'h0000; e.err = 1'b1;
        e.ord = mdl_rd[1]; e.oerr = mdl_err[1];
        q_done.push_back(e);
        mdl_rd[0] = 16'h0000; mdl_err[0] = 1'b1; mdl_xact = mdl_xact + 16'd1;
        repeat (Tmo + 2) @(posedge clk);
        #1;
        chk("tmo_xact", 32'(bus.xact_count), 32'(mdl_xact));
        chk("tmo_busy", 32'(bus.busy), 32'd0);
      end
`else
      repeat (150) @(posedge clk);
      #1;
      chk("no_tmo_busy", 32'(bus.busy), 32'd1);
      chk("no_tmo_abort", 32'(bus.ctl_abort), 32'd0);
      respond(0, 1'b1, 8'h32, 1, 16'h0F0F, 1'b0);
`endif
    end else drop_valid(0);

    // Reset, then both requesters valid and held: grants req0, req1, req0.
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cont_who[0] = 0; cont_who[1] = 1; cont_who[2] = 0;
    cont_rd[0] = 16'h1111; cont_rd[1] = 16'h2222; cont_rd[2] = 16'h3333;
    set_req(0, 1'b1, 8'h32, 8'h01, 8'h00);
    set_req(1, 1'b1, 8'h3C, 8'h02, 8'h00);
    for (int i = 0; i < 3; i++) begin
      await_grant(cont_who[i], t, ok);
      if (!ok) break;
      if (cont_who[i] == 0) push_start(t + 1, 1'b1, 8'h32, 8'h01, 8'h00);
      else                  push_start(t + 1, 1'b1, 8'h3C, 8'h02, 8'h00);
      @(posedge clk); #1;
      if (i == 2) begin
        drop_valid(0);
        drop_valid(1);
      end
      respond(cont_who[i], 1'b1, (cont_who[i] == 0) ? 8'h32 : 8'h3C, 2, cont_rd[i], 1'b0);
    end
    drop_valid(0);
    drop_valid(1);

    // Reset while in WAIT, then a late ctl_done: no done pulse, count stays 0.
    set_req(0, 1'b0, 8'h32, 8'h44, 8'h99);
    await_grant(0, t, ok);
    if (ok) begin
      push_start(t + 1, 1'b0, 8'h32, 8'h44, 8'h99);
      @(posedge clk); #1;
      drop_valid(0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      reset_checks();
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      bus.ctl_done = 1'b1;
      @(posedge clk); #1;
      bus.ctl_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wait_xact", 32'(bus.xact_count), 32'd0);
      chk("rst_wait_busy", 32'(bus.busy), 32'd0);
    end else drop_valid(0);

    repeat (2) @(posedge clk);
    #1;
    chk("start_q_empty", 32'(q_start.size()), 32'd0);
    chk("done_q_empty", 32'(q_done.size()), 32'd0);
    chk("abort_q_empty", 32'(q_abort.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "bench timeout");
  end

endmodule
